// File: rtl/alu_mc.sv
// ---------------------------------------------------------------------------
// alu_mc : multi-cycle execute-stage ALU.
//
// Single-cycle ops (arithmetic, logic, compare, shift, LUI, HI/LO moves)
// complete with a registered result one cycle after acceptance, back to back.
// MULT/MULTU/DIV/DIVU run an iterative datapath (one bit per cycle) on the
// operand magnitudes, apply the sign in a separate cycle, then write HI/LO.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid        request strobe, taken when in_ready=1
//   in_ready        request can be accepted this cycle
//   ALUC            5-bit operation code
//   A, B            operands (A[SHW-1:0] is the shift amount, B is shifted)
//   out_valid       one-cycle pulse: result/zero freshly updated
//   result, zero    registered result and flag
//   hi, lo          HI/LO registers
//   busy            multiply/divide in progress (= !in_ready)
//
// WIDTH must be even and >= 8; SHW must equal log2(WIDTH).
// ---------------------------------------------------------------------------
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       ALUC,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
);

    localparam int HALF = WIDTH / 2;

    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,
        OP_SUB   = 5'd1,
        OP_AND   = 5'd2,
        OP_OR    = 5'd3,
        OP_NOR   = 5'd4,
        OP_XOR   = 5'd5,
        OP_SLT   = 5'd6,
        OP_SLTU  = 5'd7,
        OP_EQL   = 5'd8,
        OP_BNE   = 5'd9,
        OP_SLL   = 5'd10,
        OP_SRL   = 5'd11,
        OP_SRA   = 5'd12,
        OP_LUI   = 5'd13,
        OP_MULT  = 5'd14,
        OP_MULTU = 5'd15,
        OP_DIV   = 5'd16,
        OP_DIVU  = 5'd17,
        OP_MFHI  = 5'd18,
        OP_MFLO  = 5'd19,
        OP_MTHI  = 5'd20,
        OP_MTLO  = 5'd21
    } alu_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_SIGN,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    // Iterative datapath state. acc holds {upper, lower}:
    //   multiply: {partial product, remaining multiplier bits}
    //   divide:   {partial remainder, dividend bits / quotient bits}
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opb_q;      // |B|: multiplicand or divisor
    logic [WIDTH-1:0]   a_raw_q;    // original A, the remainder on divide-by-zero
    logic [SHW-1:0]     cnt_q;
    logic               sa_q, sb_q; // operand signs (always 0 for unsigned ops)
    logic               div_q;      // 1: divide in flight, 0: multiply
    logic               dvz_q;      // divisor was zero

    logic accept;
    logic is_long, is_div_op, is_signed_op;
    logic last_step;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH-1:0] short_res;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift, div_diff;
    logic [WIDTH-1:0] hi_fin, lo_fin;

    assign in_ready  = (state_q == S_IDLE) || (state_q == S_DONE);
    assign busy      = !in_ready;
    assign accept    = in_valid && in_ready;
    assign last_step = (cnt_q == SHW'(WIDTH - 1));

    // -----------------------------------------------------------------------
    // Request decode
    // -----------------------------------------------------------------------
    // NOTE: every signal driven from always_comb gets a default on entry so
    // no path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        is_long      = 1'b0;
        is_div_op    = 1'b0;
        is_signed_op = 1'b0;
        case (ALUC)
            OP_MULT:  begin is_long = 1'b1; is_signed_op = 1'b1; end
            OP_MULTU: begin is_long = 1'b1; end
            OP_DIV:   begin is_long = 1'b1; is_div_op = 1'b1; is_signed_op = 1'b1; end
            OP_DIVU:  begin is_long = 1'b1; is_div_op = 1'b1; end
            default:  ;
        endcase
    end

    assign abs_a = (is_signed_op && A[WIDTH-1]) ? ('0 - A) : A;
    assign abs_b = (is_signed_op && B[WIDTH-1]) ? ('0 - B) : B;

    // -----------------------------------------------------------------------
    // Single-cycle result; reserved codes fall through to ADD
    // -----------------------------------------------------------------------
    always_comb begin
        short_res = A + B;
        case (ALUC)
            OP_SUB:  short_res = A - B;
            OP_AND:  short_res = A & B;
            OP_OR:   short_res = A | B;
            OP_NOR:  short_res = ~(A | B);
            OP_XOR:  short_res = A ^ B;
            OP_SLT:  short_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: short_res = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_SLL:  short_res = B << A[SHW-1:0];
            OP_SRL:  short_res = B >> A[SHW-1:0];
            OP_SRA:  short_res = $signed(B) >>> A[SHW-1:0];
            OP_LUI:  short_res = {B[HALF-1:0], {HALF{1'b0}}};
            OP_MFHI: short_res = hi;
            OP_MFLO: short_res = lo;
            default: short_res = A + B;
        endcase
    end

    // -----------------------------------------------------------------------
    // Iteration step
    // -----------------------------------------------------------------------
    // Shift-add: add the multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right. The
    // carry lands in the MSB after the shift.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);

    // Restoring divide: shift the next dividend bit into the remainder and
    // try subtracting the divisor; the borrow bit decides the quotient bit.
    assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_shift - {1'b0, opb_q};

    // Sign correction applied in S_SIGN. Quotient is negative when the signs
    // differ (truncation toward zero); remainder follows the dividend.
    always_comb begin
        hi_fin = '0;
        lo_fin = '0;
        if (div_q) begin
            if (dvz_q) begin
                lo_fin = '1;
                hi_fin = a_raw_q;
            end else begin
                lo_fin = (sa_q ^ sb_q) ? ('0 - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
                hi_fin = sa_q ? ('0 - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
            end
        end else begin
            {hi_fin, lo_fin} = (sa_q ^ sb_q) ? ('0 - acc_q) : acc_q;
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM
    // -----------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so all
    // registers update together from pre-edge values, independent of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept && is_long) begin
                    state_d = is_div_op ? S_DIV : S_MUL;
                end
            end
            S_MUL, S_DIV: begin
                if (last_step) begin
                    state_d = S_SIGN;
                end
            end
            S_SIGN:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath and output registers
    // -----------------------------------------------------------------------
    // NOTE: the scratch registers are reset along with the architectural ones
    // so an aborted multiply/divide leaves nothing stale behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            result    <= '0;
            zero      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            out_valid <= 1'b0;
            acc_q     <= '0;
            opb_q     <= '0;
            a_raw_q   <= '0;
            cnt_q     <= '0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            div_q     <= 1'b0;
            dvz_q     <= 1'b0;
        end else begin
            out_valid <= 1'b0;

            case (state_q)
                S_MUL: begin
                    acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
                    cnt_q <= cnt_q + 1'b1;
                end
                S_DIV: begin
                    if (!div_diff[WIDTH]) begin
                        acc_q <= {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_q <= {acc_q[2*WIDTH-2:0], 1'b0};
                    end
                    cnt_q <= cnt_q + 1'b1;
                end
                S_SIGN: begin
                    // HI/LO land on entry to DONE, so an MFHI/MFLO accepted
                    // in the DONE cycle already reads the new values.
                    hi        <= hi_fin;
                    lo        <= lo_fin;
                    result    <= lo_fin;
                    zero      <= ({hi_fin, lo_fin} == '0);
                    out_valid <= 1'b1;
                end
                default: ;
            endcase

            // Acceptance only happens in IDLE/DONE, never alongside S_SIGN.
            if (accept) begin
                if (is_long) begin
                    acc_q   <= {{WIDTH{1'b0}}, abs_a};
                    opb_q   <= abs_b;
                    a_raw_q <= A;
                    cnt_q   <= '0;
                    sa_q    <= is_signed_op && A[WIDTH-1];
                    sb_q    <= is_signed_op && B[WIDTH-1];
                    div_q   <= is_div_op;
                    dvz_q   <= (B == '0);
                end else begin
                    out_valid <= 1'b1;
                    case (ALUC)
                        OP_MTHI: hi <= A;
                        OP_MTLO: lo <= A;
                        OP_EQL:  zero <= (A == B);
                        OP_BNE:  zero <= (A != B);
                        default: begin
                            result <= short_res;
                            zero   <= (short_res == '0);
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// ---------------------------------------------------------------------------
// tb_alu_mc : self-checking bench for alu_mc (WIDTH=32 and WIDTH=16 builds).
// Requests push their expected result onto a scoreboard; a monitor on the
// falling edge pops and compares whenever the 32-bit DUT pulses out_valid.
// Latency is counted in cycles after the driving edge: short ops appear in
// cycle 1, multiply/divide in cycle WIDTH+2.
// ---------------------------------------------------------------------------
module tb_alu_mc;

    localparam int W = 32;

    typedef struct {
        logic [31:0] res;
        logic        z;
        bit          chk_hilo;
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
        string       name;
    } exp_t;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        string       name;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 32-bit DUT
    logic        in_valid, in_ready, out_valid, zero, busy;
    logic [4:0]  aluc;
    logic [31:0] a, b, result, hi, lo;

    // 16-bit DUT
    logic        in_valid16, in_ready16, out_valid16, zero16, busy16;
    logic [4:0]  aluc16;
    logic [15:0] a16, b16, result16, hi16, lo16;

    alu_mc #(.WIDTH(32), .SHW(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ALUC(aluc), .A(a), .B(b), .out_valid(out_valid), .result(result),
        .zero(zero), .hi(hi), .lo(lo), .busy(busy)
    );

    alu_mc #(.WIDTH(16), .SHW(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .ALUC(aluc16), .A(a16), .B(b16), .out_valid(out_valid16), .result(result16),
        .zero(zero16), .hi(hi16), .lo(lo16), .busy(busy16)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] res, input logic z, input bit chk,
                                input logic [31:0] h, input logic [31:0] l, input string nm);
        exp_t e;
        e.res      = res;
        e.z        = z;
        e.chk_hilo = chk;
        e.hi       = h;
        e.lo       = l;
        e.due      = 0;
        e.name     = nm;
        return e;
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out_valid: got out_valid=1 (result=0x%08h), expected no pending request", result);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_result"}, result, mon_e.res);
                check({mon_e.name, "_zero"}, 32'(zero), 32'(mon_e.z));
                check({mon_e.name, "_latency"}, 32'(cyc), 32'(mon_e.due));
                if (mon_e.chk_hilo) begin
                    check({mon_e.name, "_hi"}, hi, mon_e.hi);
                    check({mon_e.name, "_lo"}, lo, mon_e.lo);
                end
            end
        end
    end

    // Wait (at falling edges) until the DUT can accept. With spam set, keep a
    // random request asserted the whole time it is busy.
    task automatic wait_ready(input bit spam);
        int n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            if (spam) begin
                in_valid = 1'b1;
                aluc     = 5'($urandom_range(0, 31));
                a        = $urandom;
                b        = $urandom;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_ready_timeout: in_ready stayed %b for %0d cycles, expected 1", in_ready, n);
        end
        in_valid = 1'b0;
    endtask

    // Drive one request for a single cycle (caller is at a falling edge with
    // in_ready=1) and record what it must produce.
    task automatic drive(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv, input exp_t e);
        in_valid = 1'b1;
        aluc     = op;
        a        = av;
        b        = bv;
        e.due    = cyc + ((op >= 5'd14 && op <= 5'd17) ? (W + 2) : 1);
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv, input exp_t e);
        wait_ready(1'b0);
        drive(op, av, bv, e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

    initial begin
        int n;
        int c0;

        vecs[0]  = '{5'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, "add_wrap"};
        vecs[1]  = '{5'd1,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, "sub_zero"};
        vecs[2]  = '{5'd6,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, "slt"};
        vecs[3]  = '{5'd7,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, "sltu"};
        vecs[4]  = '{5'd12, 32'h0000_0004, 32'h8000_0000, 32'hF800_0000, 1'b0, "sra"};
        vecs[5]  = '{5'd13, 32'h0000_0000, 32'h0000_1234, 32'h1234_0000, 1'b0, "lui"};
        vecs[6]  = '{5'd8,  32'h0000_0007, 32'h0000_0007, 32'h1234_0000, 1'b1, "eql"};
        vecs[7]  = '{5'd9,  32'h0000_0007, 32'h0000_0007, 32'h1234_0000, 1'b0, "bne"};
        vecs[8]  = '{5'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, "and"};
        vecs[9]  = '{5'd3,  32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 1'b0, "or"};
        vecs[10] = '{5'd4,  32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0000_0000, 1'b1, "nor"};
        vecs[11] = '{5'd5,  32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, "xor"};
        vecs[12] = '{5'd10, 32'h0000_001F, 32'h0000_0003, 32'h8000_0000, 1'b0, "sll_31"};
        vecs[13] = '{5'd11, 32'h0000_0024, 32'h8000_0000, 32'h0800_0000, 1'b0, "srl_amt_low_bits"};
        vecs[14] = '{5'd1,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, "sub_wrap"};
        vecs[15] = '{5'd25, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b0, "reserved_add"};

        rst = 1'b1;
        in_valid = 1'b0; aluc = '0; a = '0; b = '0;
        in_valid16 = 1'b0; aluc16 = '0; a16 = '0; b16 = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_result", result, 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single-cycle ops, one per cycle
        foreach (vecs[i]) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b, mk(vecs[i].res, vecs[i].z, 1'b0, '0, '0, vecs[i].name));
        end

        // Multiply
        send(5'd14, 32'hFFFF_FFFD, 32'd7, mk(32'hFFFF_FFEB, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg"));
        send(5'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"));
        send(5'd14, 32'd0, 32'hFFFF_FFFB, mk(32'd0, 1'b1, 1'b1, 32'd0, 32'd0, "mult_zero"));

        // Divide
        send(5'd16, 32'hFFFF_FFF9, 32'd2, mk(32'hFFFF_FFFD, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg"));
        send(5'd17, 32'd100, 32'd0, mk(32'hFFFF_FFFF, 1'b0, 1'b1, 32'd100, 32'hFFFF_FFFF, "divu_by0"));
        wait_ready(1'b1);   // requests while busy must be dropped
        send(5'd16, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'h8000_0000, 1'b0, 1'b1, 32'd0, 32'h8000_0000, "div_min_m1"));
        send(5'd16, 32'hFFFF_FFFB, 32'd0, mk(32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_by0_signed"));

        // HI/LO moves (hi=0xFFFFFFFB, lo=0xFFFFFFFF from the last divide)
        send(5'd0, 32'd1, 32'd1, mk(32'd2, 1'b0, 1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFF, "add_keeps_hilo"));
        send(5'd20, 32'h0000_ABCD, 32'd0, mk(32'd2, 1'b0, 1'b1, 32'h0000_ABCD, 32'hFFFF_FFFF, "mthi"));
        send(5'd21, 32'd0, 32'd0, mk(32'd2, 1'b0, 1'b1, 32'h0000_ABCD, 32'd0, "mtlo"));
        send(5'd18, 32'd0, 32'd0, mk(32'h0000_ABCD, 1'b0, 1'b1, 32'h0000_ABCD, 32'd0, "mfhi"));
        send(5'd19, 32'd0, 32'd0, mk(32'd0, 1'b1, 1'b0, '0, '0, "mflo_zero"));

        // MFLO issued in the DONE cycle of a multiply sees the new LO
        send(5'd14, 32'd6, 32'd7, mk(32'd42, 1'b0, 1'b1, 32'd0, 32'd42, "mult_6x7"));
        wait_ready(1'b0);
        check("mflo_issued_in_done_cycle", 32'(out_valid), 32'd1);
        drive(5'd19, 32'd0, 32'd0, mk(32'd42, 1'b0, 1'b1, 32'd0, 32'd42, "mflo_bypass"));

        // Reset in the middle of a divide aborts it
        wait_ready(1'b0);
        in_valid = 1'b1; aluc = 5'd17; a = 32'd1000; b = 32'd7;
        @(negedge clk);
        in_valid = 1'b0;
        check("divu_busy_after_accept", 32'(busy), 32'd1);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);   // any out_valid here is unexpected

        // WIDTH=16 build: MULT -2 x 3
        in_valid16 = 1'b1; aluc16 = 5'd14; a16 = 16'hFFFE; b16 = 16'd3;
        c0 = cyc;
        @(negedge clk);
        in_valid16 = 1'b0;
        n = 0;
        while (out_valid16 !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL w16_timeout: out_valid16 never rose within %0d cycles, expected 18", n);
        end else begin
            check("w16_latency", 32'(cyc - c0), 32'd18);
            check("w16_hilo", {hi16, lo16}, 32'hFFFF_FFFA);
            check("w16_result", 32'(result16), 32'h0000_FFFA);
            check("w16_zero", 32'(zero16), 32'd0);
        end

        // Drain
        n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
